graph_data_writer: RTL and testbench



---
 rtl/graph_pkg.sv | 41 ++++
 rtl/graph_data_writer_if.sv | 18 +
 rtl/graph_peak_mem.sv | 57 +++++
 rtl/graph_data_writer.sv | 228 ++++++++++++++++++++++
 tb/tb_graph_data_writer.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/graph_pkg.sv
// graph_pkg
// Constants and types shared by the graph data writer and the HDMI graph
// renderer: spectrum size, bar-height width and the writer state encoding,
// plus the small height helpers used by the optional peak-hold path.
package graph_pkg;

    localparam int BIN_COUNT  = 256;
    localparam int BIN_ADDR_W = 8;
    localparam int HEIGHT_W   = 9;
    localparam int RAM_ADDR_W = BIN_ADDR_W + 1;

    typedef enum logic [0:0] {
        ST_FILL       = 1'b0,
        ST_WAIT_VSYNC = 1'b1
    } writer_state_t;

    // Held peak after one frame of decay, floored at zero.
    function automatic logic [HEIGHT_W-1:0] decay_height(
        input logic [HEIGHT_W-1:0] old,
        input logic [HEIGHT_W-1:0] step
    );
        if (old > step) begin
            return old - step;
        end else begin
            return {HEIGHT_W{1'b0}};
        end
    endfunction

    // Larger of two bar heights.
    function automatic logic [HEIGHT_W-1:0] max_height(
        input logic [HEIGHT_W-1:0] a,
        input logic [HEIGHT_W-1:0] b
    );
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/graph_data_writer_if.sv
// graph_data_writer_if
// Valid/ready stream of FFT magnitude bins into the graph data writer.
//   s_valid  source -> writer   bin valid
//   s_ready  writer -> source   writer can accept a bin
//   s_data   source -> writer   unsigned magnitude, IN_WIDTH bits
//   s_last   source -> writer   marks bin 255 of a frame
// Modports: master (bin source), slave (writer).
interface graph_data_writer_if #(
    parameter int IN_WIDTH = 16
) ();
    logic                s_valid;
    logic                s_ready;
    logic [IN_WIDTH-1:0] s_data;
    logic                s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/graph_peak_mem.sv
// graph_peak_mem
// 256x9 single-clock RAM holding the per-bin peak heights for peak-hold mode.
// Synchronous read (data valid the cycle after rd_en). Entries not written
// since reset read as zero, so the first frame after reset starts from a
// clean peak history.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rd_en, rd_addr      read request and bin address
//   rd_data             registered read data
//   wr_en, wr_addr      write strobe and bin address
//   wr_data             new peak height
import graph_pkg::*;

module graph_peak_mem (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [BIN_ADDR_W-1:0] rd_addr,
    output logic [HEIGHT_W-1:0]   rd_data,
    input  logic                  wr_en,
    input  logic [BIN_ADDR_W-1:0] wr_addr,
    input  logic [HEIGHT_W-1:0]   wr_data
);

    logic [HEIGHT_W-1:0]  mem_r [BIN_COUNT];
    logic [HEIGHT_W-1:0]  rd_raw_r;
    logic [BIN_COUNT-1:0] written_r;
    logic                 rd_seen_r;

    // Storage array write port and raw synchronous read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_raw_r <= mem_r[rd_addr];
        end
    end

    // Per-entry written flags, so unwritten entries read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written_r <= {BIN_COUNT{1'b0}};
            rd_seen_r <= 1'b0;
        end else begin
            if (wr_en) begin
                written_r[wr_addr] <= 1'b1;
            end
            if (rd_en) begin
                rd_seen_r <= written_r[rd_addr];
            end
        end
    end

    assign rd_data = rd_seen_r ? rd_raw_r : {HEIGHT_W{1'b0}};

endmodule

// File: rtl/graph_data_writer.sv
// graph_data_writer
// Writer end of the double-buffered 512x9 graph data RAM. Takes 256 FFT
// magnitude bins per frame, scales (>> SHIFT) and clamps (MAX_HEIGHT) each
// one to a bar height and writes it into the back bank. Once a complete frame
// has been written, the next vsync swaps banks so the renderer only ever sees
// a whole spectrum.
// Optional feature macro: GRAPH_PEAK_HOLD_EN -- decaying peak hold per bin,
// one extra write-pipeline stage.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   s            bin stream (graph_data_writer_if.slave)
//   vsync        one-cycle pulse at start of vertical blanking
//   wr_en        RAM write strobe
//   wr_addr      {back bank, bin index}
//   wr_data      bar height
//   bank         front bank read by the renderer
//   frame_done   one-cycle pulse on bank swap
//   err_len      sticky frame-length error
import graph_pkg::*;

module graph_data_writer #(
    parameter int IN_WIDTH   = 16,
    parameter int SHIFT      = 7,
    parameter int MAX_HEIGHT = 479,
    parameter int DECAY      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    graph_data_writer_if.slave    s,
    input  logic                  vsync,
    output logic                  wr_en,
    output logic [RAM_ADDR_W-1:0] wr_addr,
    output logic [HEIGHT_W-1:0]   wr_data,
    output logic                  bank,
    output logic                  frame_done,
    output logic                  err_len
);

    localparam logic [IN_WIDTH-1:0] MAX_IN  = IN_WIDTH'(MAX_HEIGHT);
    localparam logic [HEIGHT_W-1:0] MAX_OUT = HEIGHT_W'(MAX_HEIGHT);
    localparam logic [BIN_ADDR_W-1:0] LAST_BIN = BIN_ADDR_W'(BIN_COUNT - 1);

    writer_state_t          state_r;
    writer_state_t          state_nxt_s;
    logic [BIN_ADDR_W-1:0]  idx_r;
    logic                   ready_r;
    logic                   bank_r;
    logic                   frame_done_r;
    logic                   err_len_r;
    logic                   accept_s;
    logic                   commit_s;
    logic                   last_bin_s;
    logic [IN_WIDTH-1:0]    shifted_s;
    logic [HEIGHT_W-1:0]    scaled_s;
    logic                   beat_valid_r;
    logic [RAM_ADDR_W-1:0]  beat_addr_r;
    logic [HEIGHT_W-1:0]    beat_height_r;

    assign last_bin_s = (idx_r == LAST_BIN);
    assign s.s_ready  = ready_r;
    assign bank       = bank_r;
    assign frame_done = frame_done_r;
    assign err_len    = err_len_r;

    // Scale at full input width, then clamp to the ceiling.
    always_comb begin
        shifted_s = s.s_data >> SHIFT;
        if (shifted_s > MAX_IN) begin
            scaled_s = MAX_OUT;
        end else begin
            scaled_s = shifted_s[HEIGHT_W-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: a beat on bin 255 completes the frame; vsync commits it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (accept_s && last_bin_s) begin
                    state_nxt_s = ST_WAIT_VSYNC;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_WAIT_VSYNC: begin
                if (vsync) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_WAIT_VSYNC;
                end
            end
            default: state_nxt_s = ST_FILL;
        endcase
    end

    // FSM outputs: beat acceptance in FILL, bank commit in WAIT_VSYNC.
    always_comb begin
        accept_s = 1'b0;
        commit_s = 1'b0;
        case (state_r)
            ST_FILL:       accept_s = s.s_valid & ready_r;
            ST_WAIT_VSYNC: commit_s = vsync;
            default: begin
                accept_s = 1'b0;
                commit_s = 1'b0;
            end
        endcase
    end

    // Frame bookkeeping: bin index, ready, bank, swap pulse, length error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r        <= {BIN_ADDR_W{1'b0}};
            ready_r      <= 1'b0;
            bank_r       <= 1'b0;
            frame_done_r <= 1'b0;
            err_len_r    <= 1'b0;
        end else begin
            ready_r      <= (state_nxt_s == ST_FILL);
            frame_done_r <= commit_s;
            if (commit_s) begin
                bank_r <= ~bank_r;
            end
            if (accept_s) begin
                // Both a full frame and a short frame restart from bin 0.
                if (last_bin_s || s.s_last) begin
                    idx_r <= {BIN_ADDR_W{1'b0}};
                end else begin
                    idx_r <= idx_r + 8'd1;
                end
                // Error when s_last disagrees with the bin position.
                if (last_bin_s != s.s_last) begin
                    err_len_r <= 1'b1;
                end
            end
        end
    end

    // First write stage: latch the scaled beat and its back-bank address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_valid_r  <= 1'b0;
            beat_addr_r   <= {RAM_ADDR_W{1'b0}};
            beat_height_r <= {HEIGHT_W{1'b0}};
        end else begin
            beat_valid_r <= accept_s;
            if (accept_s) begin
                beat_addr_r   <= {~bank_r, idx_r};
                beat_height_r <= scaled_s;
            end
        end
    end

`ifdef GRAPH_PEAK_HOLD_EN
    localparam logic [HEIGHT_W-1:0] DECAY_H = HEIGHT_W'(DECAY);

    logic [HEIGHT_W-1:0]   peak_rd_s;
    logic [HEIGHT_W-1:0]   peak_old_s;
    logic [HEIGHT_W-1:0]   held_s;
    logic                  fwd_r;
    logic [HEIGHT_W-1:0]   fwd_data_r;
    logic                  wr_en_r;
    logic [RAM_ADDR_W-1:0] wr_addr_r;
    logic [HEIGHT_W-1:0]   wr_data_r;

    graph_peak_mem u_peak_mem (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (accept_s),
        .rd_addr (idx_r),
        .rd_data (peak_rd_s),
        .wr_en   (beat_valid_r),
        .wr_addr (beat_addr_r[BIN_ADDR_W-1:0]),
        .wr_data (held_s)
    );

    // New height: scaled value or decayed peak, whichever is higher. The
    // forward path covers a read issued while the same bin is being written
    // (a one-beat short frame followed straight away by bin 0).
    always_comb begin
        if (fwd_r) begin
            peak_old_s = fwd_data_r;
        end else begin
            peak_old_s = peak_rd_s;
        end
        held_s = max_height(beat_height_r, decay_height(peak_old_s, DECAY_H));
    end

    // Second write stage plus read-during-write forwarding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_r      <= 1'b0;
            fwd_data_r <= {HEIGHT_W{1'b0}};
            wr_en_r    <= 1'b0;
            wr_addr_r  <= {RAM_ADDR_W{1'b0}};
            wr_data_r  <= {HEIGHT_W{1'b0}};
        end else begin
            fwd_r      <= accept_s && beat_valid_r &&
                          (beat_addr_r[BIN_ADDR_W-1:0] == idx_r);
            fwd_data_r <= held_s;
            wr_en_r    <= beat_valid_r;
            if (beat_valid_r) begin
                wr_addr_r <= beat_addr_r;
                wr_data_r <= held_s;
            end
        end
    end

    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;
`else
    assign wr_en   = beat_valid_r;
    assign wr_addr = beat_addr_r;
    assign wr_data = beat_height_r;
`endif

endmodule

// File: tb/tb_graph_data_writer.sv
// tb_graph_data_writer
// Self-checking bench for graph_data_writer. A behavioural model tracks the
// frame position, bank, error flag and (with GRAPH_PEAK_HOLD_EN) per-bin
// peaks using plain integers, and predicts every output each cycle.
module tb_graph_data_writer;

    localparam int SHIFT = 7;
    localparam int MAXH  = 479;
    localparam int DECAY = 1;
`ifdef GRAPH_PEAK_HOLD_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync = 1'b0;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [8:0] wr_data;
    logic       bank;
    logic       frame_done;
    logic       err_len;

    graph_data_writer_if #(.IN_WIDTH(16)) s_if ();

    graph_data_writer #(
        .IN_WIDTH(16), .SHIFT(SHIFT), .MAX_HEIGHT(MAXH), .DECAY(DECAY)
    ) dut (
        .clk(clk), .rst(rst), .s(s_if.slave), .vsync(vsync),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .bank(bank), .frame_done(frame_done), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Behavioural model state.
    int          m_idx;
    bit          m_wait, m_bank, m_fd, m_err, m_rdy;
    int          m_peak [256];
    logic [18:0] pipe [$];
    logic [22:0] exp_vec;

    function automatic logic [22:0] obs();
        return {wr_en, wr_en ? wr_addr : 9'd0, wr_en ? wr_data : 9'd0,
                s_if.s_ready, bank, frame_done, err_len};
    endfunction

    function automatic int model_height(input int d, input int bin);
        int v;
        v = d >> SHIFT;
        if (v > MAXH) v = MAXH;
`ifdef GRAPH_PEAK_HOLD_EN
        begin
            int dec;
            dec = (m_peak[bin] > DECAY) ? m_peak[bin] - DECAY : 0;
            if (dec > v) v = dec;
            m_peak[bin] = v;
        end
`endif
        return v;
    endfunction

    task automatic model_reset();
        m_idx = 0; m_wait = 0; m_bank = 0; m_fd = 0; m_err = 0; m_rdy = 0;
        for (int i = 0; i < 256; i++) m_peak[i] = 0;
        pipe.delete();
        exp_vec = 23'd0;
    endtask

    // Drive one cycle, advance the model across the clock edge, settle.
    task automatic step(input bit v, input logic [15:0] d, input bit l, input bit vs);
        bit          acc, commit;
        logic [18:0] w, ew;
        int          h;
        s_if.s_valid = v; s_if.s_data = d; s_if.s_last = l; vsync = vs;
        @(posedge clk);
        acc    = v && m_rdy;
        commit = m_wait && vs;
        w      = 19'd0;
        if (acc) begin
            h = model_height(int'(d), m_idx);
            w = {1'b1, 9'(((m_bank ? 0 : 1) << 8) + m_idx), 9'(h)};
        end
        m_fd = commit;
        if (commit) begin
            m_bank = !m_bank;
            m_wait = 0;
        end
        if (acc) begin
            if (m_idx == 255) begin
                m_wait = 1;
                if (!l) m_err = 1;
                m_idx = 0;
            end else if (l) begin
                m_err = 1;
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        m_rdy = !m_wait;
        pipe.push_back(w);
        if (pipe.size() > LAT) void'(pipe.pop_front());
        ew = (pipe.size() == LAT) ? pipe[0] : 19'd0;
        exp_vec = {ew, m_rdy, m_bank, m_fd, m_err};
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_if.s_valid = 1'b0; s_if.s_data = 16'd0; s_if.s_last = 1'b0; vsync = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            if ({wr_en, wr_addr, wr_data, s_if.s_ready, bank, frame_done, err_len} !== 23'd0) begin
                n_fail++;
                $display("FAIL reset_hold %0d: got %h want 0", k, {wr_en, wr_addr, wr_data, s_if.s_ready, bank, frame_done, err_len});
            end
            n_vec++;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        step(1'b0, 16'd0, 1'b0, 1'b0);
        if (obs() !== exp_vec || s_if.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h", obs(), exp_vec);
        end
        n_vec++;
    endtask

    task automatic test_full_frame();
        int n32 = 0;
        for (int i = 0; i < 256 + 4; i++) begin
            if (i < 256) step(1'b1, 16'h1000, i == 255, 1'b0);
            else         step(1'b0, 16'h0000, 1'b0, 1'b0);
            if (wr_en === 1'b1 && wr_data === 9'd32) n32++;
            if (obs() !== exp_vec) begin
                n_fail++;
                $display("FAIL full_frame cycle %0d: got %h want %h", i, obs(), exp_vec);
            end
            n_vec++;
        end
        if (n32 != 256) begin
            n_fail++;
            $display("FAIL full_frame_count: got %0d writes of 32 want 256", n32);
        end
        n_vec++;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 16'd0, 1'b0, i == 0);
            if (obs() !== exp_vec) begin
                n_fail++;
                $display("FAIL full_frame_swap %0d: got %h want %h", i, obs(), exp_vec);
            end
            n_vec++;
        end
    endtask

    task automatic test_scaling();
        int n_max = 0, n_zero = 0;
        logic [15:0] d;
        for (int i = 0; i < 256 + 3; i++) begin
            case (i % 4)
                0:       d = 16'hFFFF;
                1:       d = 16'h007F;
                2:       d = 16'h0080;
                default: d = 16'($urandom);
            endcase
            if (i < 256) step(1'b1, d, i == 255, 1'b0);
            else         step(1'b0, 16'd0, 1'b0, i == 258);
            if (wr_en === 1'b1 && wr_addr[1:0] == 2'd0 && wr_data === 9'd479) n_max++;
            if (wr_en === 1'b1 && wr_addr[1:0] == 2'd1 && wr_data === 9'd0) n_zero++;
            if (obs() !== exp_vec) begin
                n_fail++;
                $display("FAIL scaling cycle %0d: got %h want %h", i, obs(), exp_vec);
            end
            n_vec++;
        end
        if (n_max != 64 || n_zero != 64) begin
            n_fail++;
            $display("FAIL scaling_clamp: got %0d/%0d want 64/64", n_max, n_zero);
        end
        n_vec++;
    endtask

    task automatic test_short_frame();
        logic b0;
        b0 = bank;
        for (int i = 0; i < 101 + 2; i++) begin
            if (i < 101) step(1'b1, 16'($urandom), i == 100, 1'b0);
            else         step(1'b0, 16'd0, 1'b0, 1'b1);
            if (obs() !== exp_vec) begin
                n_fail++;
                $display("FAIL short_frame cycle %0d: got %h want %h", i, obs(), exp_vec);
            end
            n_vec++;
        end
        if (bank !== b0 || err_len !== 1'b1) begin
            n_fail++;
            $display("FAIL short_no_swap: got bank %b err %b want bank %b err 1", bank, err_len, b0);
        end
        n_vec++;
        for (int i = 0; i < 256 + 3; i++) begin
            if (i < 256) step(1'b1, 16'($urandom), i == 255, 1'b0);
            else         step(1'b0, 16'd0, 1'b0, i == 257);
            if (obs() !== exp_vec) begin
                n_fail++;
                $display("FAIL short_then_full cycle %0d: got %h want %h", i, obs(), exp_vec);
            end
            n_vec++;
        end
        if (bank !== ~b0) begin
            n_fail++;
            $display("FAIL short_then_swap: got bank %b want %b", bank, ~b0);
        end
        n_vec++;
    endtask

    task automatic test_vsync_coincident();
        logic b0;
        b0 = bank;
        for (int i = 0; i < 256 + 2; i++) begin
            if (i < 256) step(1'b1, 16'($urandom), i == 255, i == 255);
            else         step(1'b0, 16'd0, 1'b0, 1'b0);
            if (obs() !== exp_vec) begin
                n_fail++;
                $display("FAIL vsync_coincident cycle %0d: got %h want %h", i, obs(), exp_vec);
            end
            n_vec++;
        end
        if (bank !== b0) begin
            n_fail++;
            $display("FAIL vsync_coincident_bank: got %b want %b", bank, b0);
        end
        n_vec++;
        step(1'b0, 16'd0, 1'b0, 1'b1);
        if (obs() !== exp_vec || bank !== ~b0) begin
            n_fail++;
            $display("FAIL vsync_second: got %h want %h", obs(), exp_vec);
        end
        n_vec++;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 16'($urandom), 1'b0, 1'b0);
            if (i == LAT - 1 && (wr_en !== 1'b1 || wr_addr !== {b0, 8'd0})) begin
                n_fail++;
                $display("FAIL next_frame_addr: got %b/%h want 1/%h", wr_en, wr_addr, {b0, 8'd0});
            end
            if (obs() !== exp_vec) begin
                n_fail++;
                $display("FAIL next_frame cycle %0d: got %h want %h", i, obs(), exp_vec);
            end
            n_vec++;
        end
    endtask

    task automatic test_reset_mid();
        test_reset();
        for (int i = 0; i < 51; i++) begin
            step(1'b1, 16'($urandom), 1'b0, 1'b0);
            if (obs() !== exp_vec) begin
                n_fail++;
                $display("FAIL pre_reset beat %0d: got %h want %h", i, obs(), exp_vec);
            end
            n_vec++;
        end
        rst = 1'b1;
        model_reset();
        #1;
        if ({wr_en, wr_addr, wr_data, s_if.s_ready, bank, frame_done, err_len} !== 23'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h want 0", {wr_en, wr_addr, wr_data, s_if.s_ready, bank, frame_done, err_len});
        end
        n_vec++;
        @(posedge clk); #1;
        rst = 1'b0;
        step(1'b0, 16'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'($urandom), 1'b0, 1'b0);
            if (i == LAT - 1 && (wr_en !== 1'b1 || wr_addr !== 9'h100)) begin
                n_fail++;
                $display("FAIL fresh_frame_addr: got %b/%h want 1/100", wr_en, wr_addr);
            end
            if (obs() !== exp_vec) begin
                n_fail++;
                $display("FAIL fresh_frame cycle %0d: got %h want %h", i, obs(), exp_vec);
            end
            n_vec++;
        end
    endtask

    task automatic test_random();
        bit v, l, vs;
        for (int i = 0; i < 3000; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            l  = (m_idx == 255) ^ ($urandom_range(0, 99) == 0);
            vs = ($urandom_range(0, 15) == 0);
            step(v, 16'($urandom_range(0, 65535) >> $urandom_range(0, 3)), l, vs);
            if (obs() !== exp_vec) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h want %h", i, obs(), exp_vec);
            end
            n_vec++;
        end
    endtask

`ifdef GRAPH_PEAK_HOLD_EN
    task automatic test_peak();
        int got;
        test_reset();
        for (int f = 0; f < 3; f++) begin
            got = -1;
            for (int i = 0; i < 256 + 3; i++) begin
                if (i < 256) step(1'b1, (f == 0 && i == 0) ? 16'(400 << SHIFT) : 16'd0, i == 255, 1'b0);
                else         step(1'b0, 16'd0, 1'b0, i == 258);
                if (i == 0 && wr_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL peak_latency frame %0d: got wr_en %b want 0", f, wr_en);
                end
                if (wr_en === 1'b1 && wr_addr[7:0] == 8'd0) got = int'(wr_data);
                if (obs() !== exp_vec) begin
                    n_fail++;
                    $display("FAIL peak frame %0d cycle %0d: got %h want %h", f, i, obs(), exp_vec);
                end
                n_vec++;
            end
            if (got != 400 - f) begin
                n_fail++;
                $display("FAIL peak_bin0 frame %0d: got %0d want %0d", f, got, 400 - f);
            end
            n_vec++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_scaling();
        test_short_frame();
        test_vsync_coincident();
        test_reset_mid();
        test_random();
`ifdef GRAPH_PEAK_HOLD_EN
        test_peak();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
